// File: rtl/mismatch_checker.sv
// mismatch_checker: counts vectors and mismatches of a 4-bit (a+b) < (c-d) comparator datapath.
// Optional macro FIRST_FAIL_CAPTURE_EN adds fail_vec, the first mismatching {a,b,c,d,out} of a run.
`default_nettype none

module mismatch_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             start,
  input  logic [CNT_W-1:0] num_tests,
  input  logic             valid,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic [3:0]       c,
  input  logic [3:0]       d,
  input  logic             out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] test_count,
  output logic [CNT_W-1:0] err_count
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic [16:0]      fail_vec
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] tc_q;
  logic [CNT_W-1:0] ec_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic [3:0]       sum_w;
  logic [3:0]       dif_w;
  logic             mismatch_w;
  logic [CNT_W-1:0] tc_d;
  logic [CNT_W-1:0] ec_d;

  // Both sides are truncated to 4 bits before the unsigned compare.
  assign sum_w      = a + b;
  assign dif_w      = c - d;
  assign mismatch_w = out != (sum_w < dif_w);
  assign tc_d       = tc_q + 1'b1;
  assign ec_d       = (&ec_q) ? ec_q : ec_q + 1'b1;

`ifdef FIRST_FAIL_CAPTURE_EN
  logic [16:0] fv_q;
  assign fail_vec = fv_q;
`endif

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      num_q   <= '0;
      tc_q    <= '0;
      ec_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
      fv_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            num_q   <= num_tests;
            tc_q    <= '0;
            ec_q    <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
            fv_q    <= '0;
`endif
          end
        end
        RUN: begin
          if (num_q == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end else if (valid) begin
            tc_q <= tc_d;
            if (mismatch_w) begin
              ec_q <= ec_d;
            end
`ifdef FIRST_FAIL_CAPTURE_EN
            // err_count never wraps, so zero means no mismatch seen yet this run.
            if (mismatch_w && ec_q == '0) begin
              fv_q <= {a, b, c, d, out};
            end
`endif
            if (tc_d == num_q) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= !mismatch_w && (ec_q == '0);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign test_count = tc_q;
  assign err_count  = ec_q;

endmodule

`default_nettype wire

// File: tb/tb_mismatch_checker.sv
// tb_mismatch_checker: scoreboard bench for mismatch_checker (CNT_W=8 main instance, CNT_W=2 saturation instance).
`default_nettype none

module tb_mismatch_checker;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset_L = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] num_tests = '0;
  logic         valid = 1'b0;
  logic [3:0]   a = '0, b = '0, c = '0, d = '0;
  logic         out = 1'b0;
  logic         busy, done, pass;
  logic [W-1:0] test_count, err_count;
  logic         start2 = 1'b0, valid2 = 1'b0;
  logic [1:0]   num2 = '0;
  logic         busy2, done2, pass2;
  logic [1:0]   tc2, ec2;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic [16:0]  fail_vec, fail_vec2;
`endif

  mismatch_checker #(.CNT_W(W)) dut (
    .clock(clock), .reset_L(reset_L), .start(start), .num_tests(num_tests),
    .valid(valid), .a(a), .b(b), .c(c), .d(d), .out(out),
    .busy(busy), .done(done), .pass(pass),
    .test_count(test_count), .err_count(err_count)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .fail_vec(fail_vec)
`endif
  );

  mismatch_checker #(.CNT_W(2)) dut2 (
    .clock(clock), .reset_L(reset_L), .start(start2), .num_tests(num2),
    .valid(valid2), .a(a), .b(b), .c(c), .d(d), .out(out),
    .busy(busy2), .done(done2), .pass(pass2),
    .test_count(tc2), .err_count(ec2)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .fail_vec(fail_vec2)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] tc;
    logic [W-1:0] ec;
    logic         busy;
    logic         done;
    logic         pass;
    logic [16:0]  fv;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  int          m_tc, m_ec, m_num;
  bit          m_run, m_done, m_pass;
  logic [16:0] m_fv;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    m_tc = 0; m_ec = 0; m_num = 0; m_run = 0; m_done = 0; m_pass = 0; m_fv = '0;
  endtask

  task automatic start_run(input int n, input string name);
    start = 1'b1;
    num_tests = W'(n);
    step();
    start = 1'b0;
    m_run = 1; m_done = 0; m_pass = 0; m_tc = 0; m_ec = 0; m_num = n; m_fv = '0;
    n_vec++;
    if (busy !== 1'b1 || done !== 1'b0 || test_count !== '0 || err_count !== '0) begin
      n_err++;
      $display("FAIL %s start: got busy=%b done=%b tc=%0d ec=%0d want busy=1 done=0 tc=0 ec=0",
               name, busy, done, test_count, err_count);
    end
  endtask

  // Drives one vector, predicts the result from the golden formula, and checks the counts.
  task automatic send_vec(input logic [3:0] va, vb, vc, vd, input logic vo, input string name);
    int   s, df;
    bit   e;
    exp_t x, y;
    s  = (int'(va) + int'(vb)) % 16;
    df = (int'(vc) - int'(vd) + 16) % 16;
    e  = s < df;
    if (m_run && m_num != 0) begin
      m_tc++;
      if (vo != e) begin
        if (m_ec == 0) m_fv = {va, vb, vc, vd, vo};
        if (m_ec < (1 << W) - 1) m_ec++;
      end
      if (m_tc == m_num) begin
        m_run = 0; m_done = 1; m_pass = (m_ec == 0);
      end
    end
    x.tc = W'(m_tc); x.ec = W'(m_ec); x.busy = m_run; x.done = m_done; x.pass = m_pass; x.fv = m_fv;
    q.push_back(x);
    a = va; b = vb; c = vc; d = vd; out = vo; valid = 1'b1;
    step();
    valid = 1'b0;
    a = 'x; b = 'x; c = 'x; d = 'x; out = 1'bx;
    y = q.pop_front();
    n_vec++;
    if (test_count !== y.tc) begin
      n_err++; $display("FAIL %s test_count: got %0d want %0d", name, test_count, y.tc);
    end
    n_vec++;
    if (err_count !== y.ec) begin
      n_err++; $display("FAIL %s err_count: got %0d want %0d", name, err_count, y.ec);
    end
    n_vec++;
    if ({busy, done, pass} !== {y.busy, y.done, y.pass}) begin
      n_err++; $display("FAIL %s busy/done/pass: got %b%b%b want %b%b%b", name, busy, done, pass,
                        y.busy, y.done, y.pass);
    end
`ifdef FIRST_FAIL_CAPTURE_EN
    n_vec++;
    if (fail_vec !== y.fv) begin
      n_err++; $display("FAIL %s fail_vec: got %h want %h", name, fail_vec, y.fv);
    end
`endif
  endtask

  task automatic test_reset();
    model_clear();
    #2;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({busy, done, pass, test_count, err_count, busy2, done2, pass2, tc2, ec2} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: got busy=%b done=%b pass=%b tc=%0d ec=%0d dut2=%b%b%b%0d%0d want all 0",
                 busy, done, pass, test_count, err_count, busy2, done2, pass2, tc2, ec2);
      end
      step();
    end
    reset_L = 1'b1;
  endtask

  task automatic test_single();
    start_run(1, "single");
    send_vec(4'd1, 4'd1, 4'd4, 4'd1, 1'b1, "single");
    n_vec++;
    if (done !== 1'b1 || pass !== 1'b1 || test_count !== 8'd1) begin
      n_err++; $display("FAIL single_final: got done=%b pass=%b tc=%0d want 1 1 1", done, pass, test_count);
    end
  endtask

  task automatic test_mismatch();
    start_run(2, "mismatch");
    send_vec(4'd15, 4'd1, 4'd1, 4'd1, 1'b0, "mismatch_v1");
    send_vec(4'd1, 4'd1, 4'd0, 4'd1, 1'b0, "mismatch_v2");
    n_vec++;
    if (err_count !== 8'd1 || pass !== 1'b0 || done !== 1'b1) begin
      n_err++; $display("FAIL mismatch_final: got ec=%0d pass=%b done=%b want 1 0 1", err_count, pass, done);
    end
`ifdef FIRST_FAIL_CAPTURE_EN
    n_vec++;
    if (fail_vec !== {4'd1, 4'd1, 4'd0, 4'd1, 1'b0}) begin
      n_err++; $display("FAIL mismatch_fail_vec: got %h want %h", fail_vec, {4'd1, 4'd1, 4'd0, 4'd1, 1'b0});
    end
`endif
  endtask

  task automatic test_zero();
    start_run(0, "zero");
    step();
    m_run = 0; m_done = 1; m_pass = 1;
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 || test_count !== '0 || err_count !== '0) begin
      n_err++; $display("FAIL zero_done: got done=%b busy=%b pass=%b tc=%0d ec=%0d want 1 0 1 0 0",
                        done, busy, pass, test_count, err_count);
    end
    send_vec(4'd3, 4'd3, 4'd9, 4'd0, 1'b0, "zero_valid_in_done");
  endtask

  task automatic test_x_idle();
    start_run(2, "xidle");
    a = 'x; b = 'x; c = 'x; d = 'x; out = 1'bx;
    repeat (3) step();
    n_vec++;
    if (busy !== 1'b1 || test_count !== '0 || err_count !== '0) begin
      n_err++; $display("FAIL xidle_hold: got busy=%b tc=%0d ec=%0d want 1 0 0", busy, test_count, err_count);
    end
    send_vec(4'd7, 4'd8, 4'd2, 4'd3, 1'b1, "xidle_v1");
    send_vec(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, "xidle_v2");
  endtask

  task automatic test_back_to_back();
    start = 1'b1; num_tests = 8'd1;
    a = 4'd1; b = 4'd1; c = 4'd4; d = 4'd1; out = 1'b0; valid = 1'b1;
    step();
    start = 1'b0; valid = 1'b0;
    m_run = 1; m_done = 0; m_pass = 0; m_tc = 0; m_ec = 0; m_num = 1; m_fv = '0;
    n_vec++;
    if (busy !== 1'b1 || test_count !== '0 || err_count !== '0) begin
      n_err++; $display("FAIL b2b_start_valid: got busy=%b tc=%0d ec=%0d want 1 0 0", busy, test_count, err_count);
    end
    send_vec(4'd2, 4'd2, 4'd5, 4'd0, 1'b1, "b2b_v1");
  endtask

  task automatic test_start_in_run();
    start_run(3, "startrun");
    send_vec(4'd5, 4'd5, 4'd1, 4'd2, 1'b1, "startrun_v1");
    start = 1'b1; num_tests = 8'd1;
    step();
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || test_count !== 8'd1) begin
      n_err++; $display("FAIL startrun_ignored: got busy=%b tc=%0d want 1 1", busy, test_count);
    end
    send_vec(4'd4, 4'd4, 4'd8, 4'd0, 1'b0, "startrun_v2");
    send_vec(4'd9, 4'd9, 4'd3, 4'd3, 1'b0, "startrun_v3");
  endtask

  task automatic test_saturate();
    start2 = 1'b1; num2 = 2'd3;
    step();
    start2 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      a = 4'd1; b = 4'd1; c = 4'd4; d = 4'd1; out = 1'b0; valid2 = 1'b1;
      step();
      valid2 = 1'b0;
      n_vec++;
      if (ec2 !== 2'(i) || tc2 !== 2'(i)) begin
        n_err++; $display("FAIL sat_count%0d: got tc=%0d ec=%0d want %0d %0d", i, tc2, ec2, i, i);
      end
    end
    valid2 = 1'b1;
    repeat (2) step();
    valid2 = 1'b0;
    n_vec++;
    if (ec2 !== 2'd3 || tc2 !== 2'd3 || done2 !== 1'b1 || pass2 !== 1'b0) begin
      n_err++; $display("FAIL sat_hold: got tc=%0d ec=%0d done=%b pass=%b want 3 3 1 0", tc2, ec2, done2, pass2);
    end
  endtask

  task automatic test_abort();
    start_run(5, "abort");
    send_vec(4'd1, 4'd2, 4'd8, 4'd1, 1'b1, "abort_v1");
    send_vec(4'd1, 4'd2, 4'd8, 4'd1, 1'b0, "abort_v2");
    reset_L = 1'b0;
    #2;
    model_clear();
    n_vec++;
    if ({busy, done, pass, test_count, err_count} !== '0) begin
      n_err++; $display("FAIL abort_async: got busy=%b done=%b pass=%b tc=%0d ec=%0d want all 0",
                        busy, done, pass, test_count, err_count);
    end
`ifdef FIRST_FAIL_CAPTURE_EN
    n_vec++;
    if (fail_vec !== '0) begin
      n_err++; $display("FAIL abort_fail_vec: got %h want 0", fail_vec);
    end
`endif
    step();
    reset_L = 1'b1;
    start_run(1, "abort_rerun");
    send_vec(4'd0, 4'd1, 4'd3, 4'd1, 1'b1, "abort_rerun_v1");
  endtask

  initial begin
    test_reset();
    test_single();
    test_mismatch();
    test_zero();
    test_x_idle();
    test_back_to_back();
    test_start_in_run();
    test_saturate();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mismatch_checker.md
MISMATCH_CHECKER -- requirements
Module: mismatch_checker

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of every counter and of num_tests.
REQ-002 clock  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 reset_L  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse that begins a run.
REQ-005 num_tests  input  CNT_W  number of vectors in the run; latched on an accepted start.
REQ-006 valid  input  1  a, b, c, d and out form one checked vector this cycle.
REQ-007 a, b, c, d  input  4 each  operands driven into the comparator datapath under test.
REQ-008 out  input  1  result produced by the datapath under test.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  high while in DONE.
REQ-011 pass  output  1  high in DONE when err_count is 0.
REQ-012 test_count  output  CNT_W  vectors checked in the current or last run.
REQ-013 err_count  output  CNT_W  mismatches found in the current or last run.
REQ-014 fail_vec  output  17  first failing vector, packed {a,b,c,d,out}; present only with the macro in REQ-031.

Function
REQ-015 The golden result SHALL be exp = ((a+b) mod 16) < ((c-d) mod 16), an unsigned comparison with both sides truncated to 4 bits.
REQ-016 The states SHALL be IDLE, RUN and DONE, with IDLE entered on reset.
REQ-017 IDLE: start SHALL go to RUN next cycle, latch num_tests, and clear test_count, err_count and fail_vec.
REQ-018 RUN: each cycle with valid=1 SHALL increment test_count at the next edge.
REQ-019 RUN: each cycle with valid=1 and out!=exp SHALL also increment err_count at the next edge.
REQ-020 Counts SHALL become visible one cycle after the sampling edge; there is no other latency.
REQ-021 RUN: the sample that makes test_count equal the latched num_tests SHALL move the state to DONE on that same edge.
REQ-022 A latched num_tests of 0 SHALL move RUN to DONE on the first cycle, with both counts 0 and pass=1.
REQ-023 DONE: all counts SHALL hold until start, which behaves exactly as in IDLE (re-run, counters cleared).
REQ-024 start during RUN SHALL be ignored; valid in IDLE or DONE SHALL be ignored.
REQ-025 A start and valid in the same IDLE/DONE cycle SHALL start the run without counting that vector.
REQ-026 err_count SHALL saturate at all-ones and never wrap.
REQ-027 Inputs a, b, c, d and out SHALL be sampled only when valid=1; X on them while valid=0 SHALL NOT affect state.

Reset
REQ-028 While reset_L=0, the state SHALL be IDLE and every output SHALL be 0 (busy, done, pass, test_count, err_count, fail_vec).
REQ-029 Reset asserted mid-run SHALL abort the run immediately, asynchronously, without reaching DONE.
REQ-030 After reset_L is deasserted, the first start SHALL be honoured on the first rising edge.

Configuration
REQ-031 Macro FIRST_FAIL_CAPTURE_EN defined: fail_vec SHALL capture {a,b,c,d,out} of the first mismatch in a run and then hold until the next start or reset.
REQ-032 Macro FIRST_FAIL_CAPTURE_EN undefined: the fail_vec port and its registers SHALL be absent, with all other behaviour unchanged.

Verification
REQ-033 start with num_tests=1, then valid with a=1, b=1, c=4, d=1, out=1 (2<3) -> DONE, test_count=1, err_count=0, pass=1.
REQ-034 num_tests=2; a=15, b=1, c=1, d=1, out=0 (0<0 false); then a=1, b=1, c=0, d=1, out=0 (2<15 true, so a mismatch) -> err_count=1, pass=0, fail_vec={1,1,0,1,0} with the macro.
REQ-035 start with num_tests=0 -> DONE one cycle later, counts 0, pass=1; a valid in DONE -> test_count stays 0.
REQ-036 CNT_W=2, num_tests=3, three mismatching vectors -> err_count=3, held, no wrap.
REQ-037 reset_L pulled low after 2 of 5 vectors -> immediate IDLE with all outputs 0; a new start with num_tests=1 and one vector -> test_count=1.
REQ-038 start pulsed during RUN after 1 of 3 vectors -> ignored; run completes with test_count=3.
